// File: rtl/channel_encoder.sv
// Transmit-side channel encoder: bit-serial CRC-8 frame or Hamming(7,4) codeword behind valid/ready.
// Optional feature macro: CHENC_HAMMING_EN (undefined: mode 1 is treated as reserved).
module channel_encoder #(
  parameter int BITS_PER_CYCLE = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  mode,
  input  logic [63:0] message,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [71:0] out
);

  localparam int N  = 64 / BITS_PER_CYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CRC  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    mode_q, mode_d;
  logic [63:0]   msg_q, msg_d;
  logic [63:0]   sh_q, sh_d;
  logic [7:0]    crc_q, crc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [71:0]   out_q, out_d;
  logic          valid_q, valid_d;
  logic [71:0]   short_res;

  // MSB-first LFSR fold of one chunk into the remainder, poly 0x18D.
  function automatic logic [7:0] crc_fold(input logic [7:0] crc,
                                          input logic [BITS_PER_CYCLE-1:0] bits);
    logic [7:0] r;
    logic       fb;
    r = crc;
    for (int i = BITS_PER_CYCLE - 1; i >= 0; i--) begin
      fb = r[7] ^ bits[i];
      r  = {r[6:0], 1'b0} ^ (fb ? 8'h8D : 8'h00);
    end
    return r;
  endfunction

`ifdef CHENC_HAMMING_EN
  function automatic logic [6:0] ham74(input logic [3:0] n);
    return {n, n[3] ^ n[2] ^ n[1], n[3] ^ n[2] ^ n[0], n[3] ^ n[1] ^ n[0]};
  endfunction

  assign short_res = (mode_q == 2'd1) ? {65'b0, ham74(msg_q[3:0])} : 72'h0;
`else
  assign short_res = 72'h0;
`endif

  // Non-CRC modes pass through CRC for one cycle so out_valid is registered at E1.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    msg_d   = msg_q;
    sh_d    = sh_q;
    crc_d   = crc_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mode_d  = mode;
          msg_d   = message;
          sh_d    = message;
          crc_d   = 8'h00;
          cnt_d   = '0;
          state_d = CRC;
        end else begin
          state_d = IDLE;
        end
      end
      CRC: begin
        if (mode_q == 2'd0) begin
          crc_d = crc_fold(crc_q, sh_q[63 -: BITS_PER_CYCLE]);
          sh_d  = sh_q << BITS_PER_CYCLE;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_d = DONE;
            out_d   = {msg_q, crc_d};
            valid_d = 1'b1;
          end else begin
            state_d = CRC;
          end
        end else begin
          state_d = DONE;
          out_d   = short_res;
          valid_d = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          out_d   = 72'h0;
          valid_d = 1'b0;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
        out_d   = 72'h0;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= 2'd0;
      msg_q   <= 64'h0;
      sh_q    <= 64'h0;
      crc_q   <= 8'h00;
      cnt_q   <= '0;
      out_q   <= 72'h0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      msg_q   <= msg_d;
      sh_q    <= sh_d;
      crc_q   <= crc_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = valid_q;
  assign out       = out_q;

endmodule

// File: tb/tb_channel_encoder.sv
// Scoreboard bench for channel_encoder: driver pushes model results, negedge monitor pops and compares.
module tb_channel_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [1:0]  mode;
  logic [63:0] message;
  logic [71:0] out;

  logic        in_valid1, in_ready1, out_valid1;
  logic [1:0]  mode1;
  logic [63:0] message1;
  logic [71:0] out1;
  logic        out_ready1;

  bit   rand_rdy  = 1'b0;
  bit   rdy_force = 1'b1;
  bit   rnd_bit   = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  typedef struct {
    logic [71:0] data;
    int          lat;
    int          acc;
    logic [1:0]  md;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  assign out_ready  = rand_rdy ? rnd_bit : rdy_force;
  assign out_ready1 = 1'b1;
  assign mode1      = 2'd0;

  channel_encoder #(.BITS_PER_CYCLE(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .message(message), .out_valid(out_valid), .out_ready(out_ready), .out(out)
  );

  channel_encoder #(.BITS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .mode(mode1),
    .message(message1), .out_valid(out_valid1), .out_ready(out_ready1), .out(out1)
  );

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(posedge clk);
      #1 rnd_bit = 1'($urandom_range(0, 1));
    end
  end

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Long division of {m, 8'h00} by the generator polynomial.
  function automatic logic [7:0] crc_ref(input logic [63:0] m);
    logic [71:0] v;
    v = {m, 8'h00};
    for (int i = 71; i >= 8; i--)
      if (v[i]) v = v ^ (72'h18D << (i - 8));
    return v[7:0];
  endfunction

  function automatic logic [6:0] ham_ref(input logic [3:0] n);
    return {n, ^(n & 4'b1110), ^(n & 4'b1101), ^(n & 4'b1011)};
  endfunction

  function automatic logic [2:0] synd(input logic [6:0] c);
    return {c[2] ^ c[6] ^ c[5] ^ c[4], c[1] ^ c[6] ^ c[5] ^ c[3], c[0] ^ c[6] ^ c[4] ^ c[3]};
  endfunction

  function automatic logic [71:0] expect_out(input logic [1:0] md, input logic [63:0] m);
    if (md == 2'd0) return {m, crc_ref(m)};
`ifdef CHENC_HAMMING_EN
    if (md == 2'd1) return {65'b0, ham_ref(m[3:0])};
`endif
    return 72'h0;
  endfunction

  task automatic send(input logic [1:0] md, input logic [63:0] m, input bit push);
    exp_t e;
    int   t;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", {71'b0, in_ready}, 72'h1);
      return;
    end
    in_valid = 1'b1;
    mode     = md;
    message  = m;
    e.data = expect_out(md, m);
    e.lat  = (md == 2'd0) ? 8 : 1;
    e.acc  = cyc + 1;
    e.md   = md;
    if (push) sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    mode     = 2'($urandom);
    message  = {$urandom(), $urandom()};
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) check("drain_timeout", 72'(sb.size()), 72'h0);
    repeat (2) @(negedge clk);
  endtask

  // Monitor: one pop per result, held-stable and zero-when-idle checks in between.
  initial begin
    exp_t        e;
    logic [71:0] held;
    bit          in_pkt, expect_drop;
    logic [6:0]  cw, flip, fixed;
    logic [2:0]  s;
    in_pkt = 1'b0;
    expect_drop = 1'b0;
    held = 72'h0;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_pkt = 1'b0;
        expect_drop = 1'b0;
      end else begin
        if (expect_drop) begin
          check("release_valid", {71'b0, out_valid}, 72'h0);
          expect_drop = 1'b0;
        end
        if (out_valid) begin
          if (!in_pkt) begin
            in_pkt = 1'b1;
            held = out;
            if (sb.size() == 0) begin
              vectors++;
              miscompares++;
              $display("FAIL unexpected_output: got %h with no request pending", out);
            end else begin
              e = sb.pop_front();
              check("result", out, e.data);
              check("latency", 72'(cyc - e.acc), 72'(e.lat));
`ifdef CHENC_HAMMING_EN
              if (e.md == 2'd1) begin
                cw = out[6:0];
                check("syndrome_zero", 72'(synd(cw)), 72'h0);
                for (int b = 0; b < 7; b++) begin
                  flip  = cw ^ (7'b1 << b);
                  s     = synd(flip);
                  fixed = flip;
                  for (int k = 0; k < 7; k++)
                    if (synd(7'b1 << k) == s) fixed = flip ^ (7'b1 << k);
                  check("single_flip_corrected", 72'(fixed), 72'(cw));
                end
              end
`endif
            end
          end else begin
            check("held_stable", out, held);
          end
          if (out_ready) begin
            in_pkt = 1'b0;
            expect_drop = 1'b1;
          end
        end else begin
          check("idle_out_zero", out, 72'h0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    logic [63:0] m;
    rst = 1'b1;
    in_valid = 1'b0;
    mode = 2'd0;
    message = 64'h0;
    in_valid1 = 1'b0;
    message1 = 64'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", {71'b0, in_ready}, 72'h1);
    check("reset_out_valid", {71'b0, out_valid}, 72'h0);
    check("reset_out", out, 72'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Zero message with out_ready already high, then the x^8 remainder case.
    rdy_force = 1'b1;
    send(2'd0, 64'h0, 1'b1);
    drain();
    send(2'd0, 64'h0000_0000_0000_0001, 1'b1);
    drain();
    check("crc_of_one_model", expect_out(2'd0, 64'h1), 72'h00_0000_0000_0000_018D);

    // Serial instance: same CRC, 64-cycle latency.
    @(negedge clk);
    in_valid1 = 1'b1;
    message1 = 64'h1;
    t = cyc + 1;
    @(posedge clk);
    #1 in_valid1 = 1'b0;
    message1 = 64'hFFFF_FFFF_FFFF_FFFF;
    begin
      int w;
      w = 0;
      @(negedge clk);
      while (!out_valid1 && w < 200) begin
        @(negedge clk);
        w++;
      end
    end
    check("bpc1_valid", {71'b0, out_valid1}, 72'h1);
    check("bpc1_latency", 72'(cyc - t), 72'd64);
    check("bpc1_out", out1, 72'h00_0000_0000_0000_018D);

    // Hamming sweep, upper message bits randomised.
    for (int n = 0; n < 16; n++) begin
      m = {$urandom(), $urandom()};
      m[3:0] = 4'(n);
      send(2'd1, m, 1'b1);
    end
    drain();
`ifdef CHENC_HAMMING_EN
    check("ham_1011_model", 72'(ham_ref(4'b1011)), 72'h59);
`endif
    send(2'd2, {$urandom(), $urandom()}, 1'b1);
    send(2'd3, {$urandom(), $urandom()}, 1'b1);
    drain();

    // Downstream stall with ignored input pulses.
    rdy_force = 1'b0;
    send(2'd0, {$urandom(), $urandom()}, 1'b1);
    t = 0;
    while (!out_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("stall_valid_up", {71'b0, out_valid}, 72'h1);
    repeat (5) begin
      @(posedge clk);
      #1 in_valid = 1'b1;
      mode = 2'($urandom);
      message = {$urandom(), $urandom()};
      @(negedge clk);
      check("stall_in_ready", {71'b0, in_ready}, 72'h0);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    rdy_force = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("in_ready_after_release", {71'b0, in_ready}, 72'h1);
    drain();

    // Reset during CRC: result lost, block idle immediately.
    send(2'd0, {$urandom(), $urandom()}, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_in_ready", {71'b0, in_ready}, 72'h1);
    check("rst_out_valid", {71'b0, out_valid}, 72'h0);
    check("rst_out", out, 72'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (12) @(negedge clk);
    send(2'd0, {$urandom(), $urandom()}, 1'b1);
    drain();

    // Randomised traffic with random downstream backpressure.
    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      m = {$urandom(), $urandom()};
      if (i == 5) m = 64'hFFFF_FFFF_FFFF_FFFF;
      send(2'($urandom_range(0, 3)), m, 1'b1);
    end
    rand_rdy = 1'b0;
    rdy_force = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
